// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field widths, opcode constants,
// the fetch FSM state type, and helpers used by fetch and decode.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned INSTR_W  = 16;

  localparam logic [OPCODE_W-1:0] OP_NOP = 5'd0;
  localparam logic [OPCODE_W-1:0] OP_LDM = 5'd13;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 5'd16;
  localparam logic [OPCODE_W-1:0] OP_JN  = 5'd17;
  localparam logic [OPCODE_W-1:0] OP_JC  = 5'd18;
  localparam logic [OPCODE_W-1:0] OP_SHL = 5'd30;
  localparam logic [OPCODE_W-1:0] OP_SHR = 5'd31;

  typedef enum logic {
    FETCH     = 1'b0,
    FETCH_IMM = 1'b1
  } fetch_state_t;

  // Instructions whose second word carries a 16-bit immediate.
  function automatic logic is_two_word(input logic [OPCODE_W-1:0] opcode);
    return (opcode == OP_LDM) || (opcode == OP_SHL) || (opcode == OP_SHR);
  endfunction

  // Conditional jump opcodes resolved downstream.
  function automatic logic is_jump(input logic [OPCODE_W-1:0] opcode);
    return (opcode == OP_JZ) || (opcode == OP_JN) || (opcode == OP_JC);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   load                capture *_d this cycle (otherwise hold)
//   flush               load a bubble (all zero); overrides load
//   instr_d/imm_d/pc_d/valid_d   next entry contents
//   instr/imm/pc/valid  registered entry
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [INSTR_W-1:0] imm_d,
  input  logic [ADDR_W-1:0]  pc_d,
  input  logic               valid_d,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] imm,
  output logic [ADDR_W-1:0]  pc,
  output logic               valid
);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      instr <= '0;
      imm   <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_d;
      imm   <= imm_d;
      pc    <= pc_d;
      valid <= valid_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory
// combinationally, merges two-word immediate instructions into a single
// IF/ID entry, and honours stalls and jump redirects.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   imem_addr        word address to instruction memory (= pc)
//   imem_data        instruction word at imem_addr, same cycle
//   stall            freeze PC, FSM and IF/ID
//   jump_taken       redirect to jump_target and flush IF/ID
//   jump_target      redirect address
//   if_instr/if_opcode/if_imm/if_pc/if_valid   IF/ID register outputs
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_data,
  input  logic                stall,
  input  logic                jump_taken,
  input  logic [ADDR_W-1:0]   jump_target,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [OPCODE_W-1:0] if_opcode,
  output logic [INSTR_W-1:0]  if_imm,
  output logic [ADDR_W-1:0]   if_pc,
  output logic                if_valid
);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_inc;
  fetch_state_t       state;
  logic [INSTR_W-1:0] hold_instr;
  logic               first_is_imm;

  logic [INSTR_W-1:0] d_instr;
  logic [INSTR_W-1:0] d_imm;
  logic [ADDR_W-1:0]  d_pc;
  logic               d_valid;

  assign imem_addr    = pc;
  assign pc_inc       = pc + ADDR_W'(1);
  assign first_is_imm = is_two_word(imem_data[INSTR_W-1 -: OPCODE_W]);
  assign if_opcode    = if_instr[INSTR_W-1 -: OPCODE_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      state      <= FETCH;
      hold_instr <= '0;
    end else if (jump_taken) begin
      pc    <= jump_target;
      state <= FETCH;
    end else if (!stall) begin
      pc <= pc_inc;
      if (state == FETCH && first_is_imm) begin
        hold_instr <= imem_data;
        state      <= FETCH_IMM;
      end else begin
        state <= FETCH;
      end
    end
  end

  // Next IF/ID entry. The first word of an immediate instruction yields a
  // bubble; the full instruction is emitted once its second word arrives.
  always_comb begin
    d_instr = '0;
    d_imm   = '0;
    d_pc    = '0;
    d_valid = 1'b0;
    case (state)
      FETCH: begin
        if (!first_is_imm) begin
          d_instr = imem_data;
          d_pc    = pc_inc;
          d_valid = 1'b1;
        end
      end
      FETCH_IMM: begin
        d_instr = hold_instr;
        d_imm   = imem_data;
        d_pc    = pc_inc;
        d_valid = 1'b1;
      end
      default: ;
    endcase
  end

  if_id_reg #(
    .ADDR_W(ADDR_W)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (!stall),
    .flush   (jump_taken),
    .instr_d (d_instr),
    .imm_d   (d_imm),
    .pc_d    (d_pc),
    .valid_d (d_valid),
    .instr   (if_instr),
    .imm     (if_imm),
    .pc      (if_pc),
    .valid   (if_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        jump_taken = 1'b0;
  logic [15:0] jump_target = '0;
  logic [15:0] if_instr;
  logic [4:0]  if_opcode;
  logic [15:0] if_imm;
  logic [15:0] if_pc;
  logic        if_valid;

  logic [15:0] mem [0:65535];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_stage #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .jump_taken  (jump_taken),
    .jump_target (jump_target),
    .if_instr    (if_instr),
    .if_opcode   (if_opcode),
    .if_imm      (if_imm),
    .if_pc       (if_pc),
    .if_valid    (if_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an instruction stream view. A fetched word either is a
  // whole instruction, or starts one that completes with the next word.
  logic [15:0] m_pc;
  logic        m_half;
  logic [15:0] m_first;
  logic [15:0] m_instr, m_imm, m_ifpc;
  logic        m_valid;
  logic        m_live = 1'b0;

  function automatic bit needs_imm(input logic [15:0] w);
    int unsigned op = int'(w >> 11);
    return op == 13 || op == 30 || op == 31;
  endfunction

  always @(posedge clk) begin
    logic [15:0] w;
    if (!rst_n) begin
      m_pc = 16'h0000; m_half = 1'b0;
      m_instr = '0; m_imm = '0; m_ifpc = '0; m_valid = 1'b0;
      m_live = 1'b1;
    end else if (jump_taken) begin
      m_pc = jump_target; m_half = 1'b0;
      m_instr = '0; m_valid = 1'b0;
    end else if (!stall) begin
      w = mem[m_pc];
      if (m_half) begin
        m_instr = m_first; m_imm = w; m_ifpc = m_pc + 16'd1; m_valid = 1'b1;
        m_half = 1'b0;
      end else if (needs_imm(w)) begin
        m_first = w; m_half = 1'b1;
        m_instr = '0; m_valid = 1'b0;
      end else begin
        m_instr = w; m_imm = '0; m_ifpc = m_pc + 16'd1; m_valid = 1'b1;
      end
      m_pc = m_pc + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("m_imem_addr", 32'(imem_addr), 32'(m_pc));
      check("m_if_valid",  32'(if_valid),  32'(m_valid));
      check("m_if_instr",  32'(if_instr),  32'(m_instr));
      check("m_if_opcode", 32'(if_opcode), 32'(m_instr >> 11));
      if (m_valid) begin
        check("m_if_imm", 32'(if_imm), 32'(m_imm));
        check("m_if_pc",  32'(if_pc),  32'(m_ifpc));
      end
    end
  end

  task automatic cyc(input logic r, input logic s, input logic j, input logic [15:0] t);
    rst_n = r; stall = s; jump_taken = j; jump_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

    // Reset then straight-line one-word instructions.
    mem[0] = 16'hC800; mem[1] = 16'h1800; mem[2] = 16'hC000;
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", 32'(if_instr), 32'd0);
    check("rst_imm",   32'(if_imm),   32'd0);
    check("rst_pc",    32'(if_pc),    32'd0);
    check("rst_addr",  32'(imem_addr), 32'd0);
    run(1);
    check("seq1_op", 32'(if_opcode), 32'd25);
    check("seq1_pc", 32'(if_pc), 32'd1);
    check("seq1_addr", 32'(imem_addr), 32'd1);
    run(1);
    check("seq2_op", 32'(if_opcode), 32'd3);
    check("seq2_pc", 32'(if_pc), 32'd2);
    run(1);
    check("seq3_op", 32'(if_opcode), 32'd24);
    check("seq3_valid", 32'(if_valid), 32'd1);
    check("seq3_pc", 32'(if_pc), 32'd3);

    // Two-word immediate instruction.
    mem[0] = 16'h6900; mem[1] = 16'hBEEF; mem[2] = 16'h2000;
    mem[3] = 16'h0000; mem[4] = 16'hC800; mem[5] = 16'h1800;
    mem[6] = 16'h6900; mem[7] = 16'h1234; mem[16'h40] = 16'h2000;
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    run(1);
    check("ldm_bubble", 32'(if_valid), 32'd0);
    run(1);
    check("ldm_op",  32'(if_opcode), 32'd13);
    check("ldm_imm", 32'(if_imm), 32'hBEEF);
    check("ldm_pc",  32'(if_pc), 32'd2);
    run(1);
    check("inc_op",  32'(if_opcode), 32'd4);
    check("inc_imm", 32'(if_imm), 32'd0);

    // Stall with opcode 25 in IF/ID and pc=5.
    run(2);
    check("pre_stall_op", 32'(if_opcode), 32'd25);
    check("pre_stall_addr", 32'(imem_addr), 32'd5);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 16'h0);
      check("stall_op",   32'(if_opcode), 32'd25);
      check("stall_pc",   32'(if_pc), 32'd5);
      check("stall_addr", 32'(imem_addr), 32'd5);
    end
    run(1);
    check("post_stall_op", 32'(if_opcode), 32'd3);
    check("post_stall_pc", 32'(if_pc), 32'd6);

    // Jump while the second word of an LDM is being fetched.
    run(1);
    check("mid_imm_addr", 32'(imem_addr), 32'd7);
    cyc(1'b1, 1'b0, 1'b1, 16'h0040);
    check("jmp_valid", 32'(if_valid), 32'd0);
    check("jmp_addr",  32'(imem_addr), 32'h40);
    run(1);
    check("jmp_next_op", 32'(if_opcode), 32'd4);
    check("jmp_next_pc", 32'(if_pc), 32'h41);

    // Jump beats stall.
    cyc(1'b1, 1'b1, 1'b1, 16'h0010);
    check("js_addr",  32'(imem_addr), 32'h10);
    check("js_valid", 32'(if_valid), 32'd0);

    // PC wrap, then reset during the second word of an LDM.
    mem[16'hFFFF] = 16'hC800; mem[0] = 16'h6900;
    cyc(1'b1, 1'b0, 1'b1, 16'hFFFF);
    run(1);
    check("wrap_addr", 32'(imem_addr), 32'd0);
    check("wrap_op",   32'(if_opcode), 32'd25);
    check("wrap_pc",   32'(if_pc), 32'd0);
    run(1);
    check("wrap_ldm_bubble", 32'(if_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    check("mrst_addr",  32'(imem_addr), 32'd0);
    check("mrst_instr", 32'(if_instr), 32'd0);
    check("mrst_valid", 32'(if_valid), 32'd0);
    check("mrst_imm",   32'(if_imm), 32'd0);
    check("mrst_pc",    32'(if_pc), 32'd0);
    run(1);
    check("mrst_fetch_bubble", 32'(if_valid), 32'd0);
    check("mrst_fetch_addr", 32'(imem_addr), 32'd1);

    // Randomized traffic; immediates are biased in to exercise the FSM.
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      case ($urandom_range(0, 7))
        0: w[15:11] = 5'd13;
        1: w[15:11] = 5'd30;
        2: w[15:11] = 5'd31;
        default: ;
      endcase
      mem[i] = w;
    end
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, j;
      logic [15:0] t;
      r = ($urandom_range(0, 99) != 0);
      s = ($urandom_range(0, 4) == 0);
      j = ($urandom_range(0, 19) == 0);
      t = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                      : 16'($urandom_range(0, 255));
      cyc(r, s, j, t);
    end

    rst_n = 1'b1; stall = 1'b0; jump_taken = 1'b0;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
